spi_sclk_gen: RTL
=================

# spi_sclk_gen

Parametrised SPI serial-clock generator for the AXI SPI interface: it divides the system clock into SCLK for one transfer of programmable length, in all four CPOL/CPHA modes. It counts SCLK edges and emits single-cycle sample and shift strobes for the shift-register datapath. A start/busy/done handshake lets the control FSM drive it directly.

## Interface
- DIV_W, 8: width of the half-period divider; half-period = clk_div_i+1 clk_i cycles.
- CNT_W, 6: width of the bit-count input; maximum transfer is 2^CNT_W-1 bits.

- clk_i  in  1  system clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  start-transfer request, level-sampled in IDLE.
- clk_div_i  in  DIV_W  half-period minus one; latched at start.
- cpol_i  in  1  SCLK idle level; latched at start.
- cpha_i  in  1  clock phase; latched at start.
- nbits_i  in  CNT_W  bits per transfer; latched at start.
- sclk_o  out  1  registered SPI clock.
- lead_o  out  1  one-cycle pulse, coincident with each leading (odd-numbered) SCLK edge.
- trail_o  out  1  one-cycle pulse, coincident with each trailing (even-numbered) SCLK edge.
- sample_o  out  1  pulse: capture MISO (lead_o when CPHA=0, trail_o when CPHA=1).
- shift_o  out  1  pulse: drive the next MOSI bit (trail_o when CPHA=0, lead_o when CPHA=1, except the final edge).
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse at end of transfer.

## Operation
- Clock is clk_i. Reset is reset_n_i, asynchronous and active-low.
- Reset values: sclk_o=0, lead_o=trail_o=sample_o=shift_o=0, busy_o=0, done_o=0, state IDLE, counters 0.
- States:
  - IDLE: sclk_o follows cpol_i, registered one cycle late. start_i=1 latches div/cpol/cpha/nbits, clears counters, and moves to RUN. If nbits_i=0, it moves to FIN instead.
  - RUN: the divider counts 0..div_q. At div_q it wraps to 0, toggles sclk_o, increments edge_cnt, and pulses lead_o or trail_o. After edge 2*nbits_q it moves to TAIL.
  - TAIL: holds sclk_o at cpol_q for div_q+1 cycles, then moves to FIN.
  - FIN: done_o=1 for one cycle, busy_o=0, then IDLE.
- busy_o=1 in RUN and TAIL.
- start_i is ignored outside IDLE. Configuration inputs changing mid-transfer have no effect.
- Edge counter width is CNT_W+1; it must not overflow at nbits=2^CNT_W-1.
- clk_div_i=0 is legal: a half-period of 1 cycle, giving SCLK = clk_i/2.
- The shift strobe is suppressed on the last edge, so exactly nbits_q-1 shift pulses occur when CPHA=0 and nbits_q-1 when CPHA=1 (the first bit is preloaded by the datapath). Exactly nbits_q sample pulses occur.
- Reset asserted mid-transfer aborts immediately to the reset values. No done_o pulse is produced.

## Timing
- Edge E0 samples start_i=1. busy_o is high from E0.
- SCLK edge k (k=1..2n) is registered at E0+k*(d+1), where d=div_q and n=nbits_q. Strobes are high in the cycle after that edge, aligned with the sclk_o change.
- TAIL ends at E0+(2n+1)*(d+1). busy_o falls and done_o rises at that edge, so busy_o is high for exactly (2n+1)*(d+1) cycles.
- nbits=0: done_o pulses at E0+1 and busy_o stays 0.
- A new start_i can be accepted at the edge after done_o, giving back-to-back transfers with one IDLE cycle between them.

## Configuration
- SPI_SCLK_GEN_PAUSE_EN: when defined, adds input pause_i (1 bit).
  - While pause_i=1 in RUN, the divider and edge counter freeze, sclk_o holds its level, and all strobes are 0. busy_o stays 1.
  - When pause_i returns to 0, counting resumes from the frozen value.
  - pause_i has no effect in IDLE, TAIL or FIN.
- Without the macro, the port does not exist and behaviour is as described above.

## Test plan
- Mode 0 (cpol=0, cpha=0), div=1, nbits=8, start pulse: sclk_o period 4 cycles, 16 edges, 8 sample pulses on rising edges, 7 shift pulses, busy_o high 34 cycles, single done_o, sclk_o ends at 0.
- Mode 3 (cpol=1, cpha=1), div=0, nbits=4: sclk_o idles at 1, period 2 cycles, first edge falling, samples on rising edges (4), busy_o high 9 cycles.
- nbits=0 start: no sclk_o edges, done_o at E0+1, busy_o never set. Then div=2, nbits=1 back-to-back: 2 edges, busy_o high 9 cycles.
- start_i held high across a whole transfer and clk_div_i changed mid-run: exactly one transfer per IDLE entry, period unchanged, and a second transfer starts the cycle after done_o.
- reset_n_i pulsed low at edge 5 of an 8-bit transfer: all outputs go to 0 immediately, no done_o, and the next start_i behaves normally.
- With SPI_SCLK_GEN_PAUSE_EN: div=1, nbits=8, pause_i high for 10 cycles after edge 3: sclk_o frozen and no strobes during the pause, busy_o high 34+10 cycles total, 16 edges.

Source files
------------

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk_i into SCLK for one transfer and emits edge/sample/shift strobes.
// Define SPI_SCLK_GEN_PAUSE_EN to add pause_i, which freezes SCLK generation while in RUN.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
`ifdef SPI_SCLK_GEN_PAUSE_EN
    input  logic             pause_i,
`endif
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [CNT_W-1:0] nbits_i,
    output logic             sclk_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             sample_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [CNT_W:0]   edge_q, edge_d, last_edge;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d;
    logic             lead_q, lead_d, trail_q, trail_d, sample_q, sample_d;
    logic             shift_q, shift_d, done_q, done_d;
    logic             pause, wrap, odd;

`ifdef SPI_SCLK_GEN_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif
    assign wrap      = cnt_q == div_q;
    assign odd       = ~edge_q[0];
    assign last_edge = {nbits_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        nbits_d  = nbits_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sclk_d   = sclk_q;
        lead_d   = 1'b0;
        trail_d  = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d = cpol_i;
                if (start_i) begin
                    div_d   = clk_div_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    nbits_d = nbits_i;
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = (nbits_i == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                    if (wrap) begin
                        sclk_d   = ~sclk_q;
                        edge_d   = edge_q + (CNT_W+1)'(1);
                        lead_d   = odd;
                        trail_d  = ~odd;
                        sample_d = cpha_q ? ~odd : odd;
                        // the last edge of the shifting kind has no further bit to drive
                        shift_d  = (cpha_q ? odd : ~odd) && (edge_q + (CNT_W+1)'(2) < last_edge);
                        state_d  = (edge_q + (CNT_W+1)'(1) == last_edge) ? S_TAIL : S_RUN;
                    end
                end
            end
            S_TAIL: begin
                sclk_d  = cpol_q;
                cnt_d   = wrap ? '0 : cnt_q + DIV_W'(1);
                state_d = wrap ? S_FIN : S_TAIL;
                done_d  = wrap;
            end
            default: begin
                // entered without done_q only on a zero-length start, which delays done by one cycle
                sclk_d  = cpol_q;
                state_d = done_q ? S_IDLE : S_FIN;
                done_d  = ~done_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            lead_q   <= 1'b0;
            trail_q  <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            nbits_q  <= nbits_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sclk_q   <= sclk_d;
            lead_q   <= lead_d;
            trail_q  <= trail_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
        end
    end

    assign sclk_o   = sclk_q;
    assign lead_o   = lead_q;
    assign trail_o  = trail_q;
    assign sample_o = sample_q;
    assign shift_o  = shift_q;
    assign busy_o   = (state_q == S_RUN) || (state_q == S_TAIL);
    assign done_o   = done_q;
endmodule
